// File: rtl/fft_pair_gather_if.sv
// Stream bundle for fft_pair_gather. Carries the serial complex sample input
// and the two-lane butterfly pair output.
interface fft_pair_gather_if #(
  parameter int FLOAT_LEN     = 20,
  parameter int HALF_ADDR_LEN = 12
);
  logic [2*FLOAT_LEN-1:0]   data_in;
  logic                     data_in_valid;
  logic                     frame_sync;
  logic [2*FLOAT_LEN-1:0]   data_out_a;
  logic [2*FLOAT_LEN-1:0]   data_out_b;
  logic                     data_out_valid;
  logic [HALF_ADDR_LEN-1:0] pair_index;
  logic                     frame_done;
  logic                     phase;

  modport master (
    output data_in, data_in_valid, frame_sync,
    input  data_out_a, data_out_b, data_out_valid, pair_index, frame_done, phase
  );

  modport slave (
    input  data_in, data_in_valid, frame_sync,
    output data_out_a, data_out_b, data_out_valid, pair_index, frame_done, phase
  );
endinterface

// File: rtl/fft_pair_gather.sv
// Radix-2 pair gatherer: buffers the first half of each N-sample frame and
// emits (x[k], x[k+N/2]) pairs while the second half streams in.
module fft_pair_gather #(
  parameter int FLOAT_LEN     = 20,
  parameter int HALF_ADDR_LEN = 12
) (
  input logic              clk,
  input logic              rst,
  fft_pair_gather_if.slave bus
);
  localparam int W     = 2 * FLOAT_LEN;
  localparam int DEPTH = 1 << HALF_ADDR_LEN;

  localparam logic [0:0]               PH_FILL   = 1'b0;
  localparam logic [0:0]               PH_PAIR   = 1'b1;
  localparam logic [HALF_ADDR_LEN:0]   CNT_ONE   = {{HALF_ADDR_LEN{1'b0}}, 1'b1};
  localparam logic [HALF_ADDR_LEN-1:0] ADDR_LAST = {HALF_ADDR_LEN{1'b1}};

  logic [W-1:0]             mem_q [DEPTH];
  logic [W-1:0]             rd_data_q;

  logic [HALF_ADDR_LEN:0]   cnt_q, cnt_d;
  logic [HALF_ADDR_LEN:0]   cur_cnt_s;
  logic [HALF_ADDR_LEN-1:0] cur_addr_s;
  logic [0:0]               cur_phase_s;
  logic                     wr_en_s;
  logic                     rd_en_s;

  logic                     dly_vld_q, dly_vld_d;
  logic [W-1:0]             dly_data_q, dly_data_d;
  logic [HALF_ADDR_LEN-1:0] dly_addr_q, dly_addr_d;

  logic [W-1:0]             out_a_q, out_a_d;
  logic [W-1:0]             out_b_q, out_b_d;
  logic                     out_vld_q, out_vld_d;
  logic [HALF_ADDR_LEN-1:0] out_idx_q, out_idx_d;
  logic                     out_done_q, out_done_d;

  // Sample position decode; frame_sync forces the accepted sample to index 0.
  always_comb begin
    cur_cnt_s = cnt_q;
    if (bus.frame_sync) begin
      cur_cnt_s = '0;
    end else begin
      cur_cnt_s = cnt_q;
    end
    cur_phase_s = cur_cnt_s[HALF_ADDR_LEN];
    cur_addr_s  = cur_cnt_s[HALF_ADDR_LEN-1:0];
    wr_en_s     = bus.data_in_valid && (cur_phase_s == PH_FILL);
    rd_en_s     = bus.data_in_valid && (cur_phase_s == PH_PAIR);
  end

  // Next-state for counter, delay stage and output registers.
  always_comb begin
    cnt_d      = cnt_q;
    dly_vld_d  = rd_en_s;
    dly_data_d = dly_data_q;
    dly_addr_d = dly_addr_q;
    out_vld_d  = dly_vld_q;
    out_a_d    = out_a_q;
    out_b_d    = out_b_q;
    out_idx_d  = out_idx_q;
    out_done_d = 1'b0;

    if (bus.data_in_valid) begin
      cnt_d = cur_cnt_s + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end

    if (rd_en_s) begin
      dly_data_d = bus.data_in;
      dly_addr_d = cur_addr_s;
    end else begin
      dly_data_d = dly_data_q;
      dly_addr_d = dly_addr_q;
    end

    // The delay stage lines the second-half sample up with the one-cycle memory read.
    if (dly_vld_q) begin
      out_a_d    = rd_data_q;
      out_b_d    = dly_data_q;
      out_idx_d  = dly_addr_q;
      out_done_d = (dly_addr_q == ADDR_LAST);
    end else begin
      out_a_d    = out_a_q;
      out_b_d    = out_b_q;
      out_idx_d  = out_idx_q;
      out_done_d = 1'b0;
    end
  end

  // Half-frame buffer: contents survive reset and are never cleared.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[cur_addr_s] <= bus.data_in;
    end
    if (rd_en_s) begin
      rd_data_q <= mem_q[cur_addr_s];
    end
  end

  // Control and output state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      dly_vld_q  <= 1'b0;
      dly_data_q <= '0;
      dly_addr_q <= '0;
      out_a_q    <= '0;
      out_b_q    <= '0;
      out_vld_q  <= 1'b0;
      out_idx_q  <= '0;
      out_done_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      dly_vld_q  <= dly_vld_d;
      dly_data_q <= dly_data_d;
      dly_addr_q <= dly_addr_d;
      out_a_q    <= out_a_d;
      out_b_q    <= out_b_d;
      out_vld_q  <= out_vld_d;
      out_idx_q  <= out_idx_d;
      out_done_q <= out_done_d;
    end
  end

  assign bus.data_out_a     = out_a_q;
  assign bus.data_out_b     = out_b_q;
  assign bus.data_out_valid = out_vld_q;
  assign bus.pair_index     = out_idx_q;
  assign bus.frame_done     = out_done_q;
  assign bus.phase          = cnt_q[HALF_ADDR_LEN];
endmodule

// File: tb/tb_fft_pair_gather.sv
// Bench for fft_pair_gather: a full-size instance (N=8192) runs the directed
// ramp/gap/resync/reset scenarios, a small instance (N=8) runs random frames.
module tb_fft_pair_gather;
  localparam int FL     = 20;
  localparam int HB     = 12;
  localparam int HS     = 2;
  localparam int HALF_B = 1 << HB;
  localparam int HALF_S = 1 << HS;

  typedef struct {
    logic [39:0] a;
    logic [39:0] b;
    int          k;
    int          due;
    logic        last;
  } pair_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fft_pair_gather_if #(.FLOAT_LEN(FL), .HALF_ADDR_LEN(HB)) bus0 ();
  fft_pair_gather_if #(.FLOAT_LEN(FL), .HALF_ADDR_LEN(HS)) bus1 ();

  fft_pair_gather #(.FLOAT_LEN(FL), .HALF_ADDR_LEN(HB)) u_big (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  fft_pair_gather #(.FLOAT_LEN(FL), .HALF_ADDR_LEN(HS)) u_small (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          ec    = 0;
  int          pos    [2];
  int          npairs [2];
  logic [39:0] fbuf   [2][HALF_B];
  pair_t       expq   [2][$];

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, ec);
    end
  endtask

  function automatic logic [39:0] cplx(int n);
    logic [31:0] u;
    u = n;
    return {u[19:0], 20'd0};
  endfunction

  function automatic logic [39:0] rnd40();
    return {8'($urandom), 32'($urandom)};
  endfunction

  // Reference: frame position, first-half array, queue of expected pairs.
  task automatic model_edge(int id, logic v, logic s, logic [39:0] x, int half);
    pair_t p;
    if (!rst) begin
      pos[id] = 0;
      expq[id].delete();
    end else if (v) begin
      if (s) pos[id] = 0;
      if (pos[id] < half) begin
        fbuf[id][pos[id]] = x;
      end else begin
        p.k    = pos[id] - half;
        p.a    = fbuf[id][p.k];
        p.b    = x;
        p.due  = ec + 1;
        p.last = (p.k == half - 1);
        expq[id].push_back(p);
      end
      pos[id] = (pos[id] + 1) % (2 * half);
    end
  endtask

  always @(posedge clk) begin
    ec++;
    model_edge(0, bus0.data_in_valid, bus0.frame_sync, bus0.data_in, HALF_B);
    model_edge(1, bus1.data_in_valid, bus1.frame_sync, bus1.data_in, HALF_S);
  end

  task automatic mon(int id, string nm, logic vld, logic [39:0] a, logic [39:0] b,
                     int idx, logic fd, logic ph, int half);
    pair_t p;
    if (!rst) begin
      check({nm, "_rst_ctl"}, 64'({vld, fd, ph}), 64'd0);
      check({nm, "_rst_a"}, 64'(a), 64'd0);
      check({nm, "_rst_b"}, 64'(b), 64'd0);
      check({nm, "_rst_idx"}, 64'(idx), 64'd0);
    end else begin
      if (expq[id].size() > 0 && expq[id][0].due == ec) begin
        p = expq[id].pop_front();
        npairs[id]++;
        check({nm, "_valid"}, 64'(vld), 64'd1);
        check({nm, "_a"}, 64'(a), 64'(p.a));
        check({nm, "_b"}, 64'(b), 64'(p.b));
        check({nm, "_idx"}, 64'(idx), 64'(p.k));
        check({nm, "_done"}, 64'(fd), p.last ? 64'd1 : 64'd0);
      end else begin
        check({nm, "_idle"}, 64'({vld, fd}), 64'd0);
      end
      check({nm, "_phase"}, 64'(ph), (pos[id] >= half) ? 64'd1 : 64'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, "big", bus0.data_out_valid, bus0.data_out_a, bus0.data_out_b,
        int'(bus0.pair_index), bus0.frame_done, bus0.phase, HALF_B);
    mon(1, "small", bus1.data_out_valid, bus1.data_out_a, bus1.data_out_b,
        int'(bus1.pair_index), bus1.frame_done, bus1.phase, HALF_S);
  end

  task automatic drive(int id, logic v, logic s, logic [39:0] d);
    if (id == 0) begin
      bus0.data_in_valid = v;
      bus0.frame_sync    = s;
      bus0.data_in       = d;
    end else begin
      bus1.data_in_valid = v;
      bus1.frame_sync    = s;
      bus1.data_in       = d;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle(int n);
    bus0.data_in_valid = 1'b0;
    bus0.frame_sync    = 1'b0;
    bus1.data_in_valid = 1'b0;
    bus1.frame_sync    = 1'b0;
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int base;
    int n;
    logic v;
    logic s;
    bus0.data_in = '0;
    bus1.data_in = '0;
    bus0.data_in_valid = 1'b0;
    bus0.frame_sync    = 1'b0;
    bus1.data_in_valid = 1'b0;
    bus1.frame_sync    = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;

    // Ramp frame followed back-to-back by an offset frame.
    base = npairs[0];
    for (int i = 0; i < 8192; i++) drive(0, 1'b1, 1'b0, cplx(i));
    for (int i = 0; i < 8192; i++) drive(0, 1'b1, 1'b0, cplx(i + 10000));
    idle(3);
    check("b2b_pairs", 64'(npairs[0] - base), 64'd8192);

    // Gapped ramp with roughly half the cycles idle.
    base = npairs[0];
    n = 0;
    while (n < 8192) begin
      if ($urandom_range(0, 1) == 1) begin
        drive(0, 1'b1, 1'b0, cplx(n));
        n++;
      end else begin
        drive(0, 1'b0, 1'b0, rnd40());
      end
    end
    idle(3);
    check("gap_pairs", 64'(npairs[0] - base), 64'd4096);

    // Resync mid-PAIR: 904 pairs before, one in flight, then a fresh frame.
    base = npairs[0];
    for (int i = 0; i < 5000; i++) drive(0, 1'b1, 1'b0, cplx(i));
    drive(0, 1'b1, 1'b1, cplx(7));
    for (int i = 1; i < 8192; i++) drive(0, 1'b1, 1'b0, cplx(i));
    idle(3);
    check("resync_pairs", 64'(npairs[0] - base), 64'd5000);

    // Asynchronous reset while pairs are streaming.
    for (int i = 0; i < 6000; i++) drive(0, 1'b1, 1'b0, cplx(i));
    rst = 1'b0;
    bus0.data_in_valid = 1'b0;
    #1;
    check("async_rst_valid", 64'(bus0.data_out_valid), 64'd0);
    check("async_rst_a", 64'(bus0.data_out_a), 64'd0);
    check("async_rst_b", 64'(bus0.data_out_b), 64'd0);
    check("async_rst_phase", 64'(bus0.phase), 64'd0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    base = npairs[0];
    for (int i = 0; i < 8192; i++) drive(0, 1'b1, 1'b0, cplx(i));
    idle(3);
    check("post_rst_pairs", 64'(npairs[0] - base), 64'd4096);

    // Small configuration: random frames, gaps and frame_sync.
    for (int f = 0; f < 100; f++) begin
      for (int j = 0; j < 12; j++) begin
        v = ($urandom_range(0, 3) != 0);
        s = v && ($urandom_range(0, 19) == 0);
        drive(1, v, s, rnd40());
      end
    end
    idle(4);
    check("small_q_empty", 64'(expq[1].size()), 64'd0);
    check("big_q_empty", 64'(expq[0].size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
